// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed LATENCY to the response.
// Define DMEM_ERR_EN to fault misaligned and out-of-range accesses instead of masking/wrapping.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic            accept, enter_resp, use_live, write_en;
  logic            op_we, illegal, fault;
  logic [31:0]     op_addr, op_wdata;
  logic [2:0]      op_funct3;
  logic [IdxW-1:0] word_idx;
  logic [1:0]      lane;
  logic [3:0]      be;
  logic [31:0]     wbytes, rd_word, ld_val;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  assign accept     = req_valid && (state_q == StIdle);
  assign enter_resp = (LATENCY == 1) ? accept : (state_q == StWait && cnt_q == CntW'(1));

  // With LATENCY=1 the commit edge is the acceptance edge, so decode the live request.
  assign use_live  = (state_q == StIdle);
  assign op_we     = use_live ? req_we     : we_q;
  assign op_addr   = use_live ? req_addr   : addr_q;
  assign op_wdata  = use_live ? req_wdata  : wdata_q;
  assign op_funct3 = use_live ? req_funct3 : funct3_q;
  assign word_idx  = op_addr[IdxW+1:2];
  assign rd_word   = mem[word_idx];

`ifndef DMEM_ERR_EN
  logic unused_addr_hi;
  assign unused_addr_hi = ^op_addr[31:IdxW+2];
`endif

  always_comb begin
    illegal = op_we ? (op_funct3 > 3'd2) : (op_funct3 == 3'b011 || op_funct3[2:1] == 2'b11);
    lane    = op_addr[1:0];
`ifdef DMEM_ERR_EN
    fault = illegal
         || (op_funct3[1:0] == 2'b01 && op_addr[0])
         || (op_funct3[1:0] == 2'b10 && op_addr[1:0] != 2'b00)
         || ((op_addr >> (IdxW + 2)) != 32'd0);
`else
    if (op_funct3[1:0] == 2'b01) begin
      lane[0] = 1'b0;
    end else if (op_funct3[1:0] == 2'b10) begin
      lane = 2'b00;
    end
    fault = illegal;
`endif
  end

  always_comb begin
    ld_byte = rd_word[{lane, 3'b000} +: 8];
    ld_half = rd_word[{lane[1], 4'b0000} +: 16];
    unique case (op_funct3[1:0])
      2'b00: begin
        be     = 4'b0001 << lane;
        wbytes = {4{op_wdata[7:0]}};
        ld_val = op_funct3[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      2'b01: begin
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wbytes = {2{op_wdata[15:0]}};
        ld_val = op_funct3[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: begin
        be     = 4'b1111;
        wbytes = op_wdata;
        ld_val = rd_word;
      end
    endcase
  end

  assign write_en = enter_resp && op_we && !fault;

  // Storage is deliberately not reset; a reset edge never commits a pending store.
  always_ff @(posedge clk) begin
    if (!reset && write_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wbytes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d     = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (enter_resp) begin
      rdata_d = (op_we || fault) ? 32'd0 : ld_val;
      err_d   = fault;
    end
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

endmodule
